// File: rtl/periph_bridge_pkg.sv
// Shared definitions for the peripheral bridge: the memory-mapped register map
// and the hex-to-seven-segment table used by the display scanner.
package periph_bridge_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TDIV   = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN    = 32'hFFFF_F078;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_DIG   = 3'd1,
    SEL_TIMER = 3'd2,
    SEL_TDIV  = 3'd3,
    SEL_LED   = 3'd4,
    SEL_SW    = 3'd5,
    SEL_BTN   = 3'd6
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      ADDR_DIG:   sel = SEL_DIG;
      ADDR_TIMER: sel = SEL_TIMER;
      ADDR_TDIV:  sel = SEL_TDIV;
      ADDR_LED:   sel = SEL_LED;
      ADDR_SW:    sel = SEL_SW;
      ADDR_BTN:   sel = SEL_BTN;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Returns {dp,g,f,e,d,c,b,a}, active-low, with the decimal point kept dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/periph_bridge_seg_scan.sv
// Multiplexed eight-digit seven-segment scanner: each digit is lit for
// SCAN_DIV cycles, with registered digit-enable and segment outputs.
module periph_bridge_seg_scan
  import periph_bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dig,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned SCAN_LAST = (SCAN_DIV > 1) ? SCAN_DIV - 1 : 0;

  logic [31:0] scan_cnt_r;
  logic [2:0]  digit_idx_r;
  logic        scan_wrap_s;
  logic [3:0]  nibble_s;
  logic [7:0]  dig_en_r;
  logic [7:0]  dig_seg_r;

  assign scan_wrap_s = (scan_cnt_r == 32'(SCAN_LAST));
  assign nibble_s    = dig[{digit_idx_r, 2'b00} +: 4];

  // Dwell counter and active digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r  <= 32'd0;
      digit_idx_r <= 3'd0;
    end else if (scan_wrap_s) begin
      scan_cnt_r  <= 32'd0;
      digit_idx_r <= digit_idx_r + 3'd1;
    end else begin
      scan_cnt_r  <= scan_cnt_r + 32'd1;
    end
  end

  // Display drive registers; blanked while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en_r  <= 8'hFF;
      dig_seg_r <= 8'hFF;
    end else begin
      dig_en_r  <= ~(8'd1 << digit_idx_r);
      dig_seg_r <= hex_to_seg(nibble_s);
    end
  end

  assign dig_en  = dig_en_r;
  assign dig_seg = dig_seg_r;

endmodule

// File: rtl/periph_bridge.sv
// CPU data-bus bridge: routes loads/stores either to DRAM or to the memory-mapped
// display, timer, LED, switch and button registers.
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic [13:0] dram_addr,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  logic        periph_hit_s;
  reg_sel_e    sel_s;
  logic        wr_dig_s;
  logic        wr_timer_s;
  logic        wr_tdiv_s;
  logic        wr_led_s;
  logic [31:0] tdiv_eff_s;
  logic        presc_wrap_s;
  logic [31:0] rdata_s;

  logic [31:0] dig_r;
  logic [31:0] timer_r;
  logic [31:0] tdiv_r;
  logic [31:0] presc_r;
  logic [23:0] led_r;
  logic [23:0] sw_meta_r;
  logic [23:0] sw_sync_r;
  logic [4:0]  btn_meta_r;
  logic [4:0]  btn_sync_r;

  assign periph_hit_s = (Bus_addr >= PERIPH_BASE);
  assign sel_s        = decode_addr(Bus_addr);
  assign wr_dig_s     = Bus_wen && (sel_s == SEL_DIG);
  assign wr_timer_s   = Bus_wen && (sel_s == SEL_TIMER);
  assign wr_tdiv_s    = Bus_wen && (sel_s == SEL_TDIV);
  assign wr_led_s     = Bus_wen && (sel_s == SEL_LED);

  assign dram_addr    = Bus_addr[15:2];
  assign dram_wdata   = Bus_wdata;
  assign dram_wen     = Bus_wen && !periph_hit_s;

  // A divisor of zero behaves like one so the timer never stalls.
  assign tdiv_eff_s   = (tdiv_r == 32'd0) ? 32'd1 : tdiv_r;
  assign presc_wrap_s = (presc_r == (tdiv_eff_s - 32'd1));

  // Two-flop synchronisers for the asynchronous switch and button pins.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sw_meta_r  <= 24'd0;
      sw_sync_r  <= 24'd0;
      btn_meta_r <= 5'd0;
      btn_sync_r <= 5'd0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= button;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Display and LED registers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      dig_r <= 32'd0;
      led_r <= 24'd0;
    end else begin
      if (wr_dig_s) dig_r <= Bus_wdata;
      if (wr_led_s) led_r <= Bus_wdata[23:0];
    end
  end

  // Prescaled timer; a CPU write takes priority over the same-cycle increment.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      tdiv_r  <= 32'(TIMER_DIV);
      presc_r <= 32'd0;
      timer_r <= 32'd0;
    end else begin
      if (wr_tdiv_s) tdiv_r <= Bus_wdata;
      if (wr_tdiv_s || presc_wrap_s) presc_r <= 32'd0;
      else                           presc_r <= presc_r + 32'd1;
      if (wr_timer_s)        timer_r <= Bus_wdata;
      else if (presc_wrap_s) timer_r <= timer_r + 32'd1;
    end
  end

  // Load data is combinational so the CPU sees it in the address cycle.
  always_comb begin
    rdata_s = 32'd0;
    if (!periph_hit_s) begin
      rdata_s = dram_rdata;
    end else begin
      case (sel_s)
        SEL_DIG:   rdata_s = dig_r;
        SEL_TIMER: rdata_s = timer_r;
        SEL_TDIV:  rdata_s = tdiv_r;
        SEL_LED:   rdata_s = {8'd0, led_r};
        SEL_SW:    rdata_s = {8'd0, sw_sync_r};
        SEL_BTN:   rdata_s = {27'd0, btn_sync_r};
        default:   rdata_s = 32'd0;
      endcase
    end
  end

  assign Bus_rdata = rdata_s;
  assign led       = led_r;

  periph_bridge_seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .dig     (dig_r),
    .dig_en  (dig_en),
    .dig_seg (dig_seg)
  );

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 Parameter SCAN_DIV, default 50000: cpu_clk cycles each seven-segment digit is lit.
REQ-002 Parameter TIMER_DIV, default 1: cpu_clk cycles per timer increment.
REQ-003 Port cpu_clk, input, 1: single clock.
REQ-004 Port cpu_rst, input, 1: reset, synchronous and active-high.
REQ-005 Port Bus_addr, input, 32: byte address from the CPU memory stage.
REQ-006 Port Bus_wen, input, 1: CPU store strobe.
REQ-007 Port Bus_wdata, input, 32: CPU store data.
REQ-008 Port Bus_rdata, output, 32: load data returned to the CPU.
REQ-009 Port dram_addr, output, 14: DRAM word address.
REQ-010 Port dram_wen, output, 1: DRAM write enable.
REQ-011 Port dram_wdata, output, 32: DRAM write data.
REQ-012 Port dram_rdata, input, 32: DRAM read data.
REQ-013 Port sw, input, 24: asynchronous switch inputs.
REQ-014 Port button, input, 5: asynchronous push-button inputs.
REQ-015 Port led, output, 24: LED drive.
REQ-016 Port dig_en, output, 8: digit enables, one-hot, active-low.
REQ-017 Port dig_seg, output, 8: segments {dp,g..a}, active-low.

Function
REQ-018 Address map (exact match): 0xFFFF_F000 DIG (R/W), 0xFFFF_F020 TIMER (R/W), 0xFFFF_F024 TDIV (R/W), 0xFFFF_F060 LED (R/W), 0xFFFF_F070 SW (RO), 0xFFFF_F078 BTN (RO).
REQ-019 Any address at or above 0xFFFF_F000 is a peripheral hit; every other address selects DRAM.
REQ-020 dram_addr = Bus_addr[15:2]; dram_wdata = Bus_wdata; dram_wen = Bus_wen AND NOT peripheral hit; all combinational.
REQ-021 Bus_rdata is combinational from the address and registered state, so the CPU captures it in the same cycle it issues the address.
REQ-022 Reads: DRAM returns dram_rdata; DIG/TIMER/TDIV/LED return their register; SW returns {8'b0, sw_sync}; BTN returns {27'b0, btn_sync}; unmapped peripheral addresses return 0.
REQ-023 A write with Bus_wen=1 to a R/W register updates it at the next cpu_clk edge; writes to SW, BTN or unmapped peripheral addresses are ignored.
REQ-024 LED register is 24 bits, loaded from Bus_wdata[23:0]; led is driven directly from it.
REQ-025 sw and button each pass through a 2-flop synchroniser; the read value lags the pin by exactly 2 cycles.
REQ-026 Timer: a prescaler counts 0..TDIV-1 (TDIV=0 treated as 1); the 32-bit TIMER register increments when the prescaler wraps, and wraps from 0xFFFF_FFFF to 0.
REQ-027 A TIMER write and an increment in the same cycle: the write wins. A TDIV write clears the prescaler.
REQ-028 Scan: a counter counts 0..SCAN_DIV-1; on wrap, the 3-bit digit index advances 0..7 and wraps to 0.
REQ-029 Digit i shows hex nibble DIG[4i+3:4i]; dig_en[i]=0 for the active digit only; dig_seg uses a standard hex 0-F decode; dp (bit 7) is held at 1 (off).
REQ-030 dig_en and dig_seg are registered and update one cycle after the digit index changes.

Reset
REQ-031 On cpu_rst=1 at a clock edge: DIG=0, TIMER=0, TDIV=TIMER_DIV, LED=0, prescaler=0, scan counter=0, digit index=0, synchronisers=0.
REQ-032 During reset, dig_en=8'hFF and dig_seg=8'hFF. Bus writes are ignored while cpu_rst=1.
REQ-033 Reset asserted mid-scan or mid-count aborts at the next edge; no partial state survives.

Structure
REQ-034 Peripheral address constants and the hex-to-segment table belong in the shared defines header.
REQ-035 One sub-module: seg_scan (scan counter, digit index, segment decode, registered dig_en/dig_seg).

Verification
REQ-036 Store 0x12345678 to 0x0000_0010, then load it -> dram_wen=1 for one cycle, dram_addr=14'h0004, and the load returns dram_rdata.
REQ-037 Store 0x00ABCDEF to 0xFFFF_F060 -> dram_wen stays 0, led=24'hABCDEF from the next cycle, and a load of 0xFFFF_F060 returns 0x00ABCDEF.
REQ-038 sw=24'h00F00F -> a load of 0xFFFF_F070 returns 0 for 2 cycles, then 0x0000F00F.
REQ-039 SCAN_DIV=4, DIG=0x0000000A -> dig_en=8'hFE with dig_seg encoding 'A' for 4 cycles, then dig_en=8'hFD with dig_seg encoding '0'.
REQ-040 TIMER_DIV=1: write 0xFFFF_FFFE to TIMER -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0; assert cpu_rst during the count -> reads 0 on the next cycle.
